// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// signed operands handled as magnitudes with a sign fix-up on completion.
module div #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam int unsigned WORK_W = 2*DATA_W + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   state_t              r_state,   w_state_nxt;
   logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
   logic [WORK_W-1:0]   r_work,    w_work_nxt;
   logic [DATA_W-1:0]   r_divisor, w_divisor_nxt;
   logic                r_neg_q,   w_neg_q_nxt;
   logic                r_neg_r,   w_neg_r_nxt;
   logic [2*DATA_W-1:0] w_result_nxt;
   logic                w_ready_nxt;

   logic                w_op1_neg, w_op2_neg;
   logic [DATA_W-1:0]   w_op1_abs, w_op2_abs;
   logic [DATA_W:0]     w_diff;
   logic [WORK_W-1:0]   w_iter;
   logic [DATA_W-1:0]   w_quo, w_rem, w_quo_fix, w_rem_fix;

   // Operand magnitudes and one restoring-division step
   always_comb begin
      w_op1_neg = signed_div_i & opdata1_i[DATA_W-1];
      w_op2_neg = signed_div_i & opdata2_i[DATA_W-1];
      w_op1_abs = w_op1_neg ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
      w_op2_abs = w_op2_neg ? (~opdata2_i + DATA_W'(1)) : opdata2_i;
      w_diff    = {1'b0, r_work[2*DATA_W-1:DATA_W]} - {1'b0, r_divisor};
      w_iter    = w_diff[DATA_W] ? {r_work[2*DATA_W-1:0], 1'b0}
                                 : {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
      w_quo     = w_iter[DATA_W-1:0];
      w_rem     = w_iter[2*DATA_W:DATA_W+1];
      w_quo_fix = r_neg_q ? (~w_quo + DATA_W'(1)) : w_quo;
      w_rem_fix = r_neg_r ? (~w_rem + DATA_W'(1)) : w_rem;
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_work_nxt    = r_work;
      w_divisor_nxt = r_divisor;
      w_neg_q_nxt   = r_neg_q;
      w_neg_r_nxt   = r_neg_r;
      w_result_nxt  = '0;
      w_ready_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  w_state_nxt = S_BYZERO;
               end else begin
                  w_state_nxt   = S_ON;
                  w_cnt_nxt     = '0;
                  w_work_nxt    = {DATA_W'(0), w_op1_abs, 1'b0};
                  w_divisor_nxt = w_op2_abs;
                  w_neg_q_nxt   = w_op1_neg ^ w_op2_neg;
                  w_neg_r_nxt   = w_op1_neg;
               end
            end
         end
         S_BYZERO: begin
            if (annul_i || !start_i) begin
               w_state_nxt = S_IDLE;
               w_work_nxt  = '0;
            end else begin
               w_state_nxt = S_END;
               w_ready_nxt = 1'b1;
            end
         end
         S_ON: begin
            if (annul_i || !start_i) begin
               w_state_nxt = S_IDLE;
               w_work_nxt  = '0;
               w_cnt_nxt   = '0;
            end else begin
               w_work_nxt = w_iter;
               w_cnt_nxt  = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(DATA_W-1)) begin
                  w_state_nxt  = S_END;
                  w_ready_nxt  = 1'b1;
                  w_result_nxt = {w_rem_fix, w_quo_fix};
               end
            end
         end
         S_END: begin
            // annul is deliberately ignored here; only dropping start leaves
            if (start_i) begin
               w_ready_nxt  = 1'b1;
               w_result_nxt = result_o;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_work    <= '0;
         r_divisor <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         result_o  <= '0;
         ready_o   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_work    <= w_work_nxt;
         r_divisor <= w_divisor_nxt;
         r_neg_q   <= w_neg_q_nxt;
         r_neg_r   <= w_neg_r_nxt;
         result_o  <= w_result_nxt;
         ready_o   <= w_ready_nxt;
      end
   end

endmodule

// File: tb/tb_div.sv
// Directed bench for the multi-cycle divider: expected results are queued on
// issue and popped when ready_o rises.
module tb_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_pass  = 0;
   int n_total = 0;
   logic [63:0] sb[$];

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic go(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      signed_div_i = s;
      opdata1_i    = a;
      opdata2_i    = b;
      annul_i      = 1'b0;
      start_i      = 1'b1;
   endtask

   // Count edges until ready_o; operands are scrambled after the load edge
   task automatic wait_ready(output int n);
      for (n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
         end
         if (ready_o) break;
      end
   endtask

   task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] res);
      int n;
      logic [63:0] e;
      sb.push_back(res);
      go(s, a, b);
      wait_ready(n);
      chk({tag, "_lat"}, 64'(n), 64'(lat));
      e = sb.pop_front();
      chk({tag, "_res"}, result_o, e);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, e[62:0]});
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_drop"}, {63'd0, ready_o} | result_o, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic any_rdy;
      logic [31:0] a, b, q, r;
      logic s;
      rst = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      start_i = 1'b0;
      annul_i = 1'b0;
      #1;
      chk("reset_ready", 64'(ready_o), 64'd0);
      chk("reset_result", result_o, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run_div("u100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
      run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
      run_div("s_7_m2", 1'b1, 32'h7, 32'hFFFFFFFE, 33, {32'h1, 32'hFFFFFFFD});
      run_div("byzero", 1'b0, 32'h12345678, 32'h0, 2, 64'd0);
      run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'h1, 33, {32'h0, 32'hFFFFFFFF});
      run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, {32'h0, 32'h80000000});
      run_div("u_big", 1'b0, 32'h80000000, 32'hFFFFFFFF, 33, {32'h80000000, 32'h0});

      for (int i = 0; i < 4; i++) begin
         s = 1'(i % 2);
         a = $urandom;
         b = $urandom >> (i * 7);
         if (b == 32'd0) b = 32'd3;
         if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
         end else begin
            q = a / b;
            r = a % b;
         end
         run_div($sformatf("rand%0d", i), s, a, b, 33, {r, q});
      end

      // Abort mid-division, then restart straight away with start still high
      go(1'b0, 32'd1000, 32'd7);
      any_rdy = 1'b0;
      repeat (11) begin
         @(posedge clk);
         #1;
         any_rdy = any_rdy | ready_o;
      end
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      any_rdy = any_rdy | ready_o;
      chk("annul_no_ready", {63'd0, any_rdy} | result_o, 64'd0);
      run_div("after_annul", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});

      // Async reset while a result is presented
      go(1'b0, 32'd5, 32'd2);
      wait_ready(n);
      chk("end_pre_rst", {63'd0, ready_o}, 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_end_ready", 64'(ready_o), 64'd0);
      chk("rst_end_result", result_o, 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      rst = 1'b1;

      // Async reset mid-division, then a fresh division
      go(1'b0, 32'd100, 32'd7);
      repeat (21) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_on_out", {63'd0, ready_o} | result_o, 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      rst = 1'b1;
      run_div("post_rst", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
